sprite_loader: RTL and testbench

SPRITE_LOADER -- requirements
Module: sprite_loader

---
 rtl/sprite_loader_if.sv | 28 ++
 rtl/sprite_loader.sv | 88 ++++++++
 tb/tb_sprite_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_loader_if.sv
// Sprite loader bus: control strobes and byte stream in, image RAM write port and status out.
interface sprite_loader_if #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256
);
  localparam int AW = $clog2(WIDTH * HEIGHT);

  logic          start_in;
  logic          abort_in;
  logic [7:0]    data_in;
  logic          valid_in;
  logic          ready_out;
  logic [AW-1:0] waddr_out;
  logic [7:0]    wdata_out;
  logic          we_out;
  logic          busy_out;
  logic          done_out;

  modport master (
    output start_in, abort_in, data_in, valid_in,
    input  ready_out, waddr_out, wdata_out, we_out, busy_out, done_out
  );

  modport slave (
    input  start_in, abort_in, data_in, valid_in,
    output ready_out, waddr_out, wdata_out, we_out, busy_out, done_out
  );
endinterface

// File: rtl/sprite_loader.sv
// Streams one WIDTH x HEIGHT sprite of palette bytes into image RAM in raster order.
module sprite_loader #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256
) (
  input  logic pixel_clk_in,
  input  logic rst_in,
  sprite_loader_if.slave bus
);
  localparam int AW = $clog2(WIDTH * HEIGHT);
  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] addr_p0;
  logic          accept_p0;
  logic          last_p0;

  logic [AW-1:0] waddr_p1;
  logic [7:0]    wdata_p1;
  logic          vld_p1;

  assign accept_p0 = (state == LOAD) && bus.valid_in && !bus.abort_in;
  assign last_p0   = (col == COL_LAST) && (row == ROW_LAST);

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      addr_p0  <= '0;
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start_in) begin
            state   <= LOAD;
            col     <= '0;
            row     <= '0;
            addr_p0 <= '0;
          end
        end
        LOAD: begin
          if (bus.abort_in) begin
            state <= IDLE;
          end else if (accept_p0) begin
            // p0 -> p1: register the accepted byte with the address of its pixel
            vld_p1   <= 1'b1;
            waddr_p1 <= addr_p0;
            wdata_p1 <= bus.data_in;
            if (last_p0) begin
              state   <= DONE;
              col     <= '0;
              row     <= '0;
              addr_p0 <= '0;
            end else begin
              addr_p0 <= addr_p0 + 1'b1;
              if (col == COL_LAST) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_out = (state == LOAD);
  assign bus.busy_out  = (state == LOAD);
  assign bus.done_out  = (state == DONE);
  assign bus.we_out    = vld_p1;
  assign bus.waddr_out = waddr_p1;
  assign bus.wdata_out = wdata_p1;
endmodule

// File: tb/tb_sprite_loader.sv
// Directed bench for sprite_loader: 4x2 instance for function, 256x256 instance for full size.
module tb_sprite_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sprite_loader_if #(.WIDTH(4), .HEIGHT(2)) s_if ();
  sprite_loader_if #(.WIDTH(256), .HEIGHT(256)) b_if ();

  sprite_loader #(.WIDTH(4), .HEIGHT(2)) u_small (
    .pixel_clk_in(clk), .rst_in(rst), .bus(s_if.slave)
  );
  sprite_loader #(.WIDTH(256), .HEIGHT(256)) u_big (
    .pixel_clk_in(clk), .rst_in(rst), .bus(b_if.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // write monitor for the small instance
  int mon_addr [32];
  int mon_data [32];
  int mon_cnt  = 0;
  int done_cnt = 0;
  int done_addr = 0;
  int done_we = 0;

  always @(negedge clk) begin
    if (s_if.we_out) begin
      if (mon_cnt < 32) begin
        mon_addr[mon_cnt] = int'(s_if.waddr_out);
        mon_data[mon_cnt] = int'(s_if.wdata_out);
      end
      mon_cnt++;
    end
    if (s_if.done_out) begin
      done_cnt++;
      done_addr = int'(s_if.waddr_out);
      done_we   = int'(s_if.we_out);
    end
  end

  // monitor for the full-size instance
  int big_wr_cnt = 0;
  int big_seq_err = 0;
  int big_last_addr = 0;
  int big_done_cnt = 0;
  int big_done_addr = 0;

  always @(negedge clk) begin
    if (b_if.we_out) begin
      if (int'(b_if.waddr_out) != big_wr_cnt) big_seq_err++;
      big_last_addr = int'(b_if.waddr_out);
      big_wr_cnt++;
    end
    if (b_if.done_out) begin
      big_done_cnt++;
      big_done_addr = int'(b_if.waddr_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_cnt  = 0;
    done_cnt = 0;
    done_addr = 0;
    done_we = 0;
  endtask

  task automatic idle_inputs();
    s_if.start_in = 1'b0;
    s_if.abort_in = 1'b0;
    s_if.valid_in = 1'b0;
    s_if.data_in  = 8'h00;
  endtask

  task automatic do_start();
    s_if.start_in = 1'b1;
    tick();
    s_if.start_in = 1'b0;
  endtask

  task automatic send_bytes(input int n, input logic [7:0] d0);
    for (int i = 0; i < n; i++) begin
      s_if.valid_in = 1'b1;
      s_if.data_in  = d0 + 8'(i);
      tick();
    end
    s_if.valid_in = 1'b0;
  endtask

  task automatic expect_seq(input string tag, input int base, input int n, input logic [7:0] d0);
    for (int i = 0; i < n; i++) begin
      check_val({tag, "_addr"}, 32'(mon_addr[base + i]), 32'(i));
      check_val({tag, "_data"}, 32'(mon_data[base + i]), 32'(d0 + 8'(i)));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, 32'(s_if.ready_out), 32'd0);
    check_val({tag, "_we"},    32'(s_if.we_out),    32'd0);
    check_val({tag, "_done"},  32'(s_if.done_out),  32'd0);
    check_val({tag, "_busy"},  32'(s_if.busy_out),  32'd0);
    check_val({tag, "_waddr"}, 32'(s_if.waddr_out), 32'd0);
    check_val({tag, "_wdata"}, 32'(s_if.wdata_out), 32'd0);
  endtask

  initial begin
    idle_inputs();
    b_if.start_in = 1'b0;
    b_if.abort_in = 1'b0;
    b_if.valid_in = 1'b0;
    b_if.data_in  = 8'h00;

    // reset state
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();

    // back-to-back load with exact one-cycle write latency
    clear_mon();
    do_start();
    check_val("t1_ready_load", 32'(s_if.ready_out), 32'd1);
    check_val("t1_busy_load",  32'(s_if.busy_out),  32'd1);
    for (int i = 0; i < 8; i++) begin
      s_if.valid_in = 1'b1;
      s_if.data_in  = 8'h10 + 8'(i);
      tick();
      check_val("t1_we",    32'(s_if.we_out),    32'd1);
      check_val("t1_waddr", 32'(s_if.waddr_out), 32'(i));
      check_val("t1_wdata", 32'(s_if.wdata_out), 32'(8'h10 + 8'(i)));
      check_val("t1_done",  32'(s_if.done_out),  (i == 7) ? 32'd1 : 32'd0);
      check_val("t1_ready", 32'(s_if.ready_out), (i == 7) ? 32'd0 : 32'd1);
    end
    s_if.valid_in = 1'b0;
    tick();
    check_val("t1_we_after",   32'(s_if.we_out),    32'd0);
    check_val("t1_done_after", 32'(s_if.done_out),  32'd0);
    check_val("t1_hold_addr",  32'(s_if.waddr_out), 32'd7);
    check_val("t1_hold_data",  32'(s_if.wdata_out), 32'h17);
    check_val("t1_done_cnt",   32'(done_cnt),       32'd1);

    // valid toggled every other cycle
    clear_mon();
    do_start();
    for (int k = 0; k < 16; k++) begin
      s_if.valid_in = (k % 2 == 0);
      s_if.data_in  = 8'h10 + 8'(k / 2);
      tick();
    end
    s_if.valid_in = 1'b0;
    tick();
    tick();
    check_val("t2_count", 32'(mon_cnt), 32'd8);
    expect_seq("t2", 0, 8, 8'h10);
    check_val("t2_done_cnt",  32'(done_cnt),  32'd1);
    check_val("t2_done_addr", 32'(done_addr), 32'd7);
    check_val("t2_done_we",   32'(done_we),   32'd1);

    // abort after three bytes, then restart (start beats abort in IDLE)
    clear_mon();
    do_start();
    send_bytes(3, 8'h30);
    s_if.abort_in = 1'b1;
    s_if.valid_in = 1'b1;
    s_if.data_in  = 8'h99;
    tick();
    check_val("t3_abort_ready", 32'(s_if.ready_out), 32'd0);
    check_val("t3_abort_done",  32'(s_if.done_out),  32'd0);
    s_if.valid_in = 1'b0;
    s_if.start_in = 1'b1;
    tick();
    check_val("t3_abort_we",   32'(s_if.we_out),    32'd0);
    check_val("t3_start_wins", 32'(s_if.ready_out), 32'd1);
    s_if.start_in = 1'b0;
    s_if.abort_in = 1'b0;
    send_bytes(8, 8'hA0);
    tick();
    check_val("t3_count", 32'(mon_cnt), 32'd11);
    expect_seq("t3a", 0, 3, 8'h30);
    expect_seq("t3b", 3, 8, 8'hA0);
    check_val("t3_done_cnt", 32'(done_cnt), 32'd1);

    // reset mid-load has priority over everything
    clear_mon();
    do_start();
    send_bytes(5, 8'h40);
    rst = 1'b1;
    s_if.start_in = 1'b1;
    s_if.valid_in = 1'b1;
    s_if.data_in  = 8'h77;
    tick();
    check_reset_outputs("t4_rst");
    rst = 1'b0;
    idle_inputs();
    tick();
    check_val("t4_no_done", 32'(done_cnt), 32'd0);
    do_start();
    send_bytes(8, 8'h50);
    tick();
    check_val("t4_count", 32'(mon_cnt), 32'd13);
    expect_seq("t4a", 0, 5, 8'h40);
    expect_seq("t4b", 5, 8, 8'h50);
    check_val("t4_done_cnt", 32'(done_cnt), 32'd1);

    // valid in IDLE ignored, start pulses during LOAD ignored
    clear_mon();
    s_if.valid_in = 1'b1;
    s_if.data_in  = 8'hEE;
    tick();
    tick();
    tick();
    check_val("t5_idle_writes", 32'(mon_cnt), 32'd0);
    s_if.start_in = 1'b1;
    tick();
    check_val("t5_start_we", 32'(s_if.we_out), 32'd0);
    for (int i = 0; i < 8; i++) begin
      s_if.start_in = (i % 2 == 1);
      s_if.valid_in = 1'b1;
      s_if.data_in  = 8'h60 + 8'(i);
      tick();
    end
    idle_inputs();
    tick();
    check_val("t5_count", 32'(mon_cnt), 32'd8);
    expect_seq("t5", 0, 8, 8'h60);
    check_val("t5_done_cnt", 32'(done_cnt), 32'd1);

    // full-size 256x256 load
    check_val("t6_addr_width", 32'($bits(b_if.waddr_out)), 32'd16);
    b_if.start_in = 1'b1;
    tick();
    b_if.start_in = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      b_if.valid_in = 1'b1;
      b_if.data_in  = 8'(i);
      tick();
    end
    b_if.valid_in = 1'b0;
    tick();
    tick();
    check_val("t6_wr_cnt",    32'(big_wr_cnt),    32'd65536);
    check_val("t6_seq_err",   32'(big_seq_err),   32'd0);
    check_val("t6_last_addr", 32'(big_last_addr), 32'hFFFF);
    check_val("t6_done_cnt",  32'(big_done_cnt),  32'd1);
    check_val("t6_done_addr", 32'(big_done_addr), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
